mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//  Shares one pipelined Montgomery/K-RED modular multiplier (`MO_MUL`, fixed latency MUL_STAGE_CNT)
//  between N_REQ requesters (butterfly units, pointwise-mul engine). Round-robin grant, one issue per
//  cycle, per-issue tag pipeline routes each product back to its requester. A drain FSM quiesces the unit.
// PARAMETERS
//  N_REQ          4                number of requesters, >=2
//  DATA_WIDTH     ntt_pkg value    operand width
//  MUL_STAGE_CNT  ntt_pkg value    multiplier latency, cycles from mul_a/mul_b to mul_result, >=1
// PORTS
//  clk          in   1                        clock
//  rst          in   1                        synchronous, active-low reset
//  req_valid    in   [N_REQ]                  requester i has an operand pair
//  req_ready    out  [N_REQ]                  grant; handshake = req_valid[i] & req_ready[i]
//  req_a/req_b  in   [N_REQ][DATA_WIDTH]      operands, unsigned, < Q
//  mul_a/mul_b  out  [DATA_WIDTH]             registered operands to multiplier
//  mul_result   in   signed [DATA_WIDTH:0]    multiplier output
//  rsp_valid    out  [N_REQ]                  one-hot; product for requester i on rsp_data
//  rsp_data     out  signed [DATA_WIDTH:0]    mul_result passed through unmodified (no extra reduction)
//  drain        in   1                        level: stop granting, flush pipeline
//  idle         out  1                        no grant pending, tag pipeline empty, FSM in IDLE
// BEHAVIOUR
//  Reset (rst==0 at posedge): req_ready=0, mul_a=mul_b=0, rsp_valid=0, rsp_data=0, idle=1,
//   rr pointer=0, all tags invalid, FSM=IDLE. Reset mid-operation discards in-flight tags: no rsp_valid
//   for pre-reset issues.
//  Arbitration: req_ready combinational, at most one bit set; winner = first i with req_valid[i],
//   searching from rr pointer upward mod N_REQ. After a handshake rr <= winner+1 (wrap N_REQ-1 -> 0);
//   no handshake -> rr unchanged. req_ready=0 for all unless FSM=RUN.
//  Issue: on handshake, mul_a/mul_b <= req_a/req_b[winner]; tag stage 0 <= {valid=1, id=winner}.
//   No handshake: mul_a/mul_b hold, tag stage 0 valid=0 (bubble).
//  Tag pipe: MUL_STAGE_CNT+1 stages shift every cycle, no stall. rsp_valid = onehot(id) of last stage
//   when valid; rsp_data = mul_result same cycle (combinational). Latency: handshake at cycle t ->
//   rsp at cycle t+1+MUL_STAGE_CNT. Responses have no backpressure; requester must accept.
//  Throughput: 1 issue/cycle sustained; responses return in issue order.
//  FSM: IDLE -> RUN when drain==0 (first cycle after reset). RUN -> DRAIN when drain==1 (grants drop
//   same cycle). DRAIN -> IDLE when all tags invalid. IDLE with drain==1 stays IDLE.
//   DRAIN with drain deasserted still finishes flush before IDLE->RUN.
//  idle = (FSM==IDLE) | (FSM==RUN & no req_valid & all tags invalid).
//  Simultaneous: handshake and drain rising same cycle -> no grant that cycle (drain wins).
// CONFIGURATION
//  MUL_ARB_STATS_EN defined: adds outputs stat_issue[N_REQ][32] (handshakes per requester) and
//   stat_stall[32] (cycles in RUN with any req_valid and no handshake) plus input stat_clr
//   (sync clear, priority over increment). Counters saturate at 2^32-1; reset to 0.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  All N_REQ valid continuously, a=i+1,b=3 -> grants cycle 0,1,2,3,0..., rsp_valid one-hot same order,
//   each rsp_data == golden `MO_MUL model of (i+1,3) mod Q, latency exactly 1+MUL_STAGE_CNT.
//  Only req 2 valid 10 cycles -> 10 consecutive grants to 2, rr=3 afterwards, 10 back-to-back rsps.
//  Issue 3 beats, assert drain -> no new req_ready, idle=0 until third rsp, then idle=1 next cycle.
//  rst=0 one cycle with 2 beats in flight -> no rsp_valid afterwards, all outputs at reset values.
//  Exhaustive a,b in [0,Q) via req 0 -> every rsp matches golden (KRED: a*b*K^L mod Q; else a*b*R^-1).
//  MUL_ARB_STATS_EN: req0,req1 valid 8 cycles -> stat_issue[0]=4, [1]=4; stat_clr -> all 0.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one pipelined modular multiplier
// between N_REQ requesters. A tag pipeline that matches the multiplier latency
// routes each product back to the requester that issued it, and a small FSM
// quiesces the unit on drain.
// Optional build macro MUL_ARB_STATS_EN adds per-requester issue counters, a
// stall counter and a stat_clr input.
module mul_share_arbiter #(
  parameter int N_REQ         = 4,
  parameter int DATA_WIDTH    = 12,
  parameter int MUL_STAGE_CNT = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req_valid,
  output logic [N_REQ-1:0]                      req_ready,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      req_a,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      req_b,
  output logic [DATA_WIDTH-1:0]                 mul_a,
  output logic [DATA_WIDTH-1:0]                 mul_b,
  input  logic signed [DATA_WIDTH:0]            mul_result,
  output logic [N_REQ-1:0]                      rsp_valid,
  output logic signed [DATA_WIDTH:0]            rsp_data,
  input  logic                                  drain,
  output logic                                  idle
`ifdef MUL_ARB_STATS_EN
  ,
  input  logic                                  stat_clr,
  output logic [N_REQ-1:0][31:0]                stat_issue,
  output logic [31:0]                           stat_stall
`endif
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [IDW-1:0]                  rr_q;
  logic [IDW-1:0]                  winner, cand;
  logic                            found, grant_en, hs;
  // Tag pipeline: stage index p matches the product's position in the multiplier.
  logic [MUL_STAGE_CNT:0]          tag_vld_p;
  logic [MUL_STAGE_CNT:0][IDW-1:0] tag_id_p;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  // Round-robin search for the first valid requester starting at rr_q.
  always_comb begin
    found  = 1'b0;
    winner = rr_q;
    cand   = rr_q;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(rr_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Grants only in RUN; a drain request suppresses the grant in the same cycle.
  assign grant_en  = rst & (state_q == ST_RUN) & ~drain;
  assign hs        = grant_en & found;
  assign req_ready = hs ? onehot(winner) : '0;

  // Next-state logic; DRAIN leaves once only the final tag stage may still hold a beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!drain) state_d = ST_RUN;
      ST_RUN:   if (drain)  state_d = ST_DRAIN;
      ST_DRAIN: if (~|tag_vld_p[MUL_STAGE_CNT-1:0]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control state, tag valids and multiplier operand registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      tag_vld_p <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      state_q   <= state_d;
      tag_vld_p <= {tag_vld_p[MUL_STAGE_CNT-1:0], hs};
      if (hs) begin
        rr_q  <= (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
        mul_a <= req_a[winner];
        mul_b <= req_b[winner];
      end
    end
  end

  // Tag ids are qualified by tag_vld_p and need no reset.
  always_ff @(posedge clk) begin
    tag_id_p <= {tag_id_p[MUL_STAGE_CNT-1:0], winner};
  end

  // ---- stage boundary: last tag stage lines up with mul_result ----
  assign rsp_valid = tag_vld_p[MUL_STAGE_CNT] ? onehot(tag_id_p[MUL_STAGE_CNT]) : '0;
  assign rsp_data  = tag_vld_p[MUL_STAGE_CNT] ? mul_result : '0;

  assign idle = (state_q == ST_IDLE) |
                ((state_q == ST_RUN) & ~|req_valid & ~|tag_vld_p);

`ifdef MUL_ARB_STATS_EN
  // Saturating issue and stall counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst || stat_clr) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (hs && stat_issue[winner] != 32'hFFFF_FFFF)
        stat_issue[winner] <= stat_issue[winner] + 32'd1;
      if ((state_q == ST_RUN) && |req_valid && !hs && stat_stall != 32'hFFFF_FFFF)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Testbench for mul_share_arbiter: a behavioural multiplier (Montgomery form,
// Q=17, R=2^5) feeds the DUT, and a transaction-level model predicts grants,
// responses, operands and idle every cycle.
module tb_mul_share_arbiter;
  localparam int N    = 4;
  localparam int DW   = 5;
  localparam int L    = 3;
  localparam int Q    = 17;
  localparam int RINV = 8;   // 32^-1 mod 17

  logic                          clk = 1'b0;
  logic                          rst;
  logic [N-1:0]                  req_valid, req_ready, rsp_valid;
  logic [N-1:0][DW-1:0]          req_a, req_b;
  logic [DW-1:0]                 mul_a, mul_b;
  logic signed [DW:0]            mul_result, rsp_data;
  logic                          drain, idle;
`ifdef MUL_ARB_STATS_EN
  logic                          stat_clr;
  logic [N-1:0][31:0]            stat_issue;
  logic [31:0]                   stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MUL_STAGE_CNT(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .drain(drain), .idle(idle)
`ifdef MUL_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_issue(stat_issue), .stat_stall(stat_stall)
`endif
  );

  function automatic int golden(int a, int b);
    return (a * b * RINV) % Q;
  endfunction

  // Behavioural multiplier with latency L from mul_a/mul_b to mul_result.
  logic signed [DW:0] mp [0:L-1];
  always @(posedge clk) begin
    mp[0] <= (DW+1)'(golden(int'(mul_a), int'(mul_b)));
    for (int s = 1; s < L; s++) mp[s] <= mp[s-1];
  end
  assign mul_result = mp[L-1];

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int first_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- transaction-level model ----------------
  typedef struct { int due; int id; int a; int b; } beat_t;
  beat_t q[$];
  int    m_mode = 0;          // 0 idle, 1 running, 2 draining
  int    m_rr   = 0;
  int    m_ma   = 0, m_mb = 0;
  int    cyc    = 0;
  logic  chk_en = 1'b0;
  int    got_grant[$];
  int    got_id[$];
  int    got_data[$];

  always @(negedge clk) begin
    if (chk_en) begin
      int w, exp_id, exp_data;
      bit grant, due_now, exp_idle;
      logic [N-1:0] exp_ready, exp_rv;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
      grant     = rst && m_mode == 1 && !drain && w >= 0;
      exp_ready = grant ? N'(1) << w : '0;
      due_now   = q.size() > 0 && q[0].due == cyc;
      exp_id    = due_now ? q[0].id : 0;
      exp_data  = due_now ? golden(q[0].a, q[0].b) : 0;
      exp_rv    = due_now ? N'(1) << exp_id : '0;
      exp_idle  = m_mode == 0 || (m_mode == 1 && req_valid == '0 && q.size() == 0);

      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_rv);
      check("rsp_data", int'(rsp_data), exp_data);
      check("idle", idle, exp_idle);
      check("mul_a", mul_a, m_ma);
      check("mul_b", mul_b, m_mb);

      if (req_ready != '0) got_grant.push_back(first_set(req_ready));
      if (rsp_valid != '0) begin
        got_id.push_back(first_set(rsp_valid));
        got_data.push_back(int'(rsp_data));
      end

      if (!rst) begin
        m_mode = 0; m_rr = 0; m_ma = 0; m_mb = 0;
        q.delete();
      end else begin
        if (due_now) void'(q.pop_front());
        if (grant) begin
          q.push_back('{cyc + 1 + L, w, int'(req_a[w]), int'(req_b[w])});
          m_rr = (w + 1) % N;
          m_ma = int'(req_a[w]);
          m_mb = int'(req_b[w]);
        end
        case (m_mode)
          0: if (!drain) m_mode = 1;
          1: if (drain) m_mode = 2;
          default: if (q.size() == 0) m_mode = 0;
        endcase
      end
      cyc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_grant.delete(); got_id.delete(); got_data.delete();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lit_data [4];
    int k, cnt;
    bit seen;
    lit_data = '{7, 14, 4, 11};   // (i+1)*3*8 mod 17

    rst = 1'b0; drain = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
`ifdef MUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    tick(1);
    chk_en = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(2);

    // All requesters valid, a=i+1, b=3: strict rotation and in-order returns.
    clear_logs();
    for (int i = 0; i < N; i++) begin
      req_a[i] = DW'(i + 1);
      req_b[i] = DW'(3);
    end
    req_valid = '1;
    tick(12);
    req_valid = '0;
    tick(L + 3);
    for (int j = 0; j < 8; j++) begin
      check("rr_order", (got_grant.size() > j) ? got_grant[j] : -1, j % N);
      check("rsp_order", (got_id.size() > j) ? got_id[j] : -1, j % N);
      check("rsp_literal", (got_data.size() > j) ? got_data[j] : -1, lit_data[j % N]);
    end

    // Only requester 2: ten back-to-back grants, then rr must point at 3.
    clear_logs();
    req_a[2] = DW'(5); req_b[2] = DW'(7);
    req_valid = 4'b0100;
    tick(10);
    req_valid = 4'b1111;
    tick(1);
    req_valid = '0;
    tick(L + 3);
    cnt = 0;
    for (int j = 0; j < got_id.size(); j++) if (got_id[j] == 2) cnt++;
    check("solo_grants", got_grant.size(), 11);
    check("solo_rsps", cnt, 10);
    check("rr_after_solo", (got_grant.size() > 10) ? got_grant[10] : -1, 3);
    check("solo_literal", (got_data.size() > 0) ? got_data[0] : -1, 8);  // 5*7*8 mod 17

    // Drain after three beats: idle rises the cycle after the third response.
    req_a[1] = DW'(2); req_b[1] = DW'(9);
    req_valid = 4'b0010;
    tick(3);
    clear_logs();
    drain = 1'b1;
    k = 0; seen = 1'b0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      if (idle) seen = 1'b1; else k++;
    end
    check("drain_to_idle", k, 4);
    check("drain_rsps", got_id.size(), 3);
    check("drain_no_grant", got_grant.size(), 0);
    tick(2);
    req_valid = '0;
    drain = 1'b0;
    tick(3);

    // Reset with two beats in flight: nothing may come back.
    req_a[0] = DW'(3); req_b[0] = DW'(4);
    req_a[3] = DW'(6); req_b[3] = DW'(1);
    req_valid = 4'b1001;
    tick(2);
    req_valid = '0;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    clear_logs();
    tick(8);
    check("rst_no_rsp", got_id.size(), 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);

    // Exhaustive operand sweep through requester 0.
    clear_logs();
    req_valid = 4'b0001;
    for (int a = 0; a < Q; a++)
      for (int b = 0; b < Q; b++) begin
        req_a[0] = DW'(a);
        req_b[0] = DW'(b);
        tick(1);
      end
    req_valid = '0;
    tick(L + 3);
    check("sweep_rsps", got_id.size(), Q * Q);

`ifdef MUL_ARB_STATS_EN
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    req_valid = 4'b0011;
    tick(8);
    req_valid = '0;
    tick(1);
    check("stat_issue0", stat_issue[0], 4);
    check("stat_issue1", stat_issue[1], 4);
    check("stat_stall", stat_stall, 0);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    check("stat_clr0", stat_issue[0], 0);
    check("stat_clr1", stat_issue[1], 0);
    tick(L + 2);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
